cache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate controller for the 8-set x 8-word cache data array (cache_regfile).

---
 rtl/cache_controller_pkg.sv | 39 +++
 rtl/cache_controller_tag_array.sv | 47 ++++
 rtl/cache_controller.sv | 127 ++++++++++++
 tb/tb_cache_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared types and address-field layout for the direct-mapped LC-3b cache controller.
// Geometry: 8 sets x 8 sixteen-bit words, 16-bit byte addresses.
package cache_controller_pkg;

    localparam int NUM_SETS   = 8;
    localparam int LINE_WORDS = 8;
    localparam int ADDR_W     = 16;
    localparam int WORD_W     = 16;
    localparam int INDEX_W    = $clog2(NUM_SETS);
    localparam int OFFSET_W   = $clog2(LINE_WORDS);
    localparam int TAG_W      = ADDR_W - 1 - OFFSET_W - INDEX_W;
    localparam int LINE_W     = WORD_W * LINE_WORDS;
    localparam int INDEX_LSB  = OFFSET_W + 1;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_W;

    typedef logic [TAG_W-1:0]    lc3b_c_tag;
    typedef logic [INDEX_W-1:0]  lc3b_c_index;
    typedef logic [OFFSET_W-1:0] lc3b_c_offset;
    typedef logic [LINE_W-1:0]   lc3b_c_line;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        ALLOCATE
    } cache_state_t;

    // Lanes not enabled keep the word currently held in the data array.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [1:0]        be,
        input logic [WORD_W-1:0] wdata,
        input logic [WORD_W-1:0] old
    );
        logic [WORD_W-1:0] merged;
        merged[15:8] = be[1] ? wdata[15:8] : old[15:8];
        merged[7:0]  = be[0] ? wdata[7:0]  : old[7:0];
        return merged;
    endfunction

endpackage

// File: rtl/cache_controller_tag_array.sv
// Per-set tag/valid/dirty bookkeeping for the cache controller.
// Single shared index for the combinational read and all write ports.
module cache_controller_tag_array
    import cache_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  lc3b_c_index index,
    input  logic        set_line,
    input  lc3b_c_tag   new_tag,
    input  logic        set_dirty,
    input  logic        clr_dirty,
    output lc3b_c_tag   tag,
    output logic        valid,
    output logic        dirty
);

    lc3b_c_tag           tag_q [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                tag_q[i] <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (set_line) begin
                tag_q[index]   <= new_tag;
                valid_q[index] <= 1'b1;
            end
            // A CPU write hit and a line clear never coincide; set wins if they ever did.
            if (set_dirty) begin
                dirty_q[index] <= 1'b1;
            end else if (clr_dirty) begin
                dirty_q[index] <= 1'b0;
            end
        end
    end

    assign tag   = tag_q[index];
    assign valid = valid_q[index];
    assign dirty = dirty_q[index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller between the LC-3b CPU
// memory port and physical memory; drives load_word/load_line of the external data array.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_byte_enable,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output lc3b_c_line        pmem_wdata,
    input  lc3b_c_line        pmem_rdata,
    input  logic              pmem_resp,
    output logic              dp_load_word,
    output logic              dp_load_line,
    output lc3b_c_index       dp_index,
    output lc3b_c_offset      dp_offset,
    output logic [WORD_W-1:0] dp_in_word,
    output lc3b_c_line        dp_in_line,
    input  logic [WORD_W-1:0] dp_data_word,
    input  lc3b_c_line        dp_data_line
);

    cache_state_t state;
    lc3b_c_tag    req_tag;
    lc3b_c_tag    set_tag;
    logic         set_valid;
    logic         set_dirty_bit;
    logic         req;
    logic         hit;
    logic         check_hit;
    logic         wb_done;
    logic         unused_addr_bit0;

    assign req_tag          = mem_address[ADDR_W-1:TAG_LSB];
    assign dp_index         = mem_address[TAG_LSB-1:INDEX_LSB];
    assign dp_offset        = mem_address[INDEX_LSB-1:1];
    assign unused_addr_bit0 = mem_address[0];

    cache_controller_tag_array u_tags (
        .clk       (clk),
        .reset_n   (reset_n),
        .index     (dp_index),
        .set_line  (dp_load_line),
        .new_tag   (req_tag),
        .set_dirty (dp_load_word),
        .clr_dirty (wb_done | dp_load_line),
        .tag       (set_tag),
        .valid     (set_valid),
        .dirty     (set_dirty_bit)
    );

    assign req       = mem_read | mem_write;
    assign hit       = set_valid && (set_tag == req_tag);
    assign check_hit = (state == CHECK) && req && hit;
    assign wb_done   = (state == WRITEBACK) && pmem_resp;

    // Hits complete combinationally; mem_write has priority if both requests are raised.
    assign mem_resp     = check_hit;
    assign mem_rdata    = check_hit ? dp_data_word : '0;
    assign dp_load_word = check_hit && mem_write;
    assign dp_load_line = (state == ALLOCATE) && pmem_resp;
    assign dp_in_word   = reset_n ? merge_bytes(mem_byte_enable, mem_wdata, dp_data_word) : '0;
    assign dp_in_line   = reset_n ? pmem_rdata : '0;

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            WRITEBACK: begin
                pmem_address = {set_tag, dp_index, {INDEX_LSB{1'b0}}};
                pmem_wdata   = dp_data_line;
            end
            ALLOCATE: pmem_address = {req_tag, dp_index, {INDEX_LSB{1'b0}}};
            default:  pmem_address = '0;
        endcase
    end

    // Miss FSM; pmem strobes are registered and cleared asynchronously with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CHECK;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (req && !hit) begin
                        if (set_dirty_bit) begin
                            state      <= WRITEBACK;
                            pmem_write <= 1'b1;
                        end else begin
                            state     <= ALLOCATE;
                            pmem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state      <= ALLOCATE;
                        pmem_write <= 1'b0;
                        pmem_read  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        state     <= CHECK;
                        pmem_read <= 1'b0;
                    end
                end
                default: begin
                    state      <= CHECK;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller with a behavioural data array and physical memory.
`timescale 1ns/1ps
module tb_cache_controller;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_read, mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address, mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         dp_load_word, dp_load_line;
    logic [2:0]   dp_index, dp_offset;
    logic [15:0]  dp_in_word, dp_data_word;
    logic [127:0] dp_in_line, dp_data_line;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .dp_load_word(dp_load_word), .dp_load_line(dp_load_line),
        .dp_index(dp_index), .dp_offset(dp_offset),
        .dp_in_word(dp_in_word), .dp_in_line(dp_in_line),
        .dp_data_word(dp_data_word), .dp_data_line(dp_data_line)
    );

    // Behavioural cache_regfile
    logic [127:0] rf [8];
    always @(posedge clk) begin
        if (dp_load_line) rf[dp_index] <= dp_in_line;
        else if (dp_load_word) rf[dp_index][{dp_offset, 4'b0} +: 16] <= dp_in_word;
    end
    assign dp_data_line = rf[dp_index];
    assign dp_data_word = rf[dp_index][{dp_offset, 4'b0} +: 16];

    // Reference contents: word 0x1234 starts as 0x5566, everything else follows a pattern.
    function automatic logic [15:0] pat(input logic [15:0] a);
        logic [15:0] wa;
        wa = {a[15:1], 1'b0};
        if (wa == 16'h1234) return 16'h5566;
        return {wa[7:0], wa[15:8]} ^ 16'h3C3C;
    endfunction

    logic [15:0]  ref_mem  [logic [15:0]];
    logic [127:0] pmem_mem [logic [15:0]];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        logic [15:0] k;
        k = {a[15:1], 1'b0};
        if (ref_mem.exists(k)) return ref_mem[k];
        return pat(k);
    endfunction

    function automatic logic [127:0] pmem_line(input logic [15:0] la);
        logic [127:0] l;
        if (pmem_mem.exists(la)) return pmem_mem[la];
        for (int w = 0; w < 8; w++) l[w*16 +: 16] = pat(la + 16'(w * 2));
        return l;
    endfunction

    // Physical memory responder with a transaction log
    typedef struct { logic w; logic [15:0] a; logic [127:0] d; } pmem_txn_t;
    pmem_txn_t pmem_log[$];
    bit pmem_auto = 1'b1;
    int pmem_cnt = 0;
    int pmem_busy = 0;
    int late_req = 0;
    int late_done = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            pmem_resp = 1'b0;
            pmem_cnt  = 0;
        end else begin
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                pmem_cnt  = 0;
            end
            if (late_req != late_done) begin
                pmem_rdata = {8{16'hDEAD}};
                pmem_resp  = 1'b1;
                late_done++;
            end else if (pmem_auto && (pmem_read || pmem_write)) begin
                pmem_busy++;
                if (pmem_cnt == 0) pmem_log.push_back('{pmem_write, pmem_address, pmem_wdata});
                pmem_cnt++;
                if (pmem_cnt == LAT) begin
                    if (pmem_write) pmem_mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = pmem_line(pmem_address);
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            assert (!(mem_read && mem_write)) else $error("illegal CPU request: read and write together");
            assert (!(pmem_read && pmem_write)) else $error("pmem_read and pmem_write both high");
            assert (!(dp_load_word && dp_load_line)) else $error("dp_load_word and dp_load_line both high");
        end
    end

    // Scoreboard
    typedef struct { logic w; logic [15:0] d; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic issue(input logic w, input logic [15:0] a, input logic [1:0] b, input logic [15:0] d);
        logic [15:0] old;
        old = ref_rd(a);
        if (w) begin
            ref_mem[{a[15:1], 1'b0}] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
        end
        sb.push_back('{w, old});
        mem_read = !w; mem_write = w; mem_address = a; mem_byte_enable = b; mem_wdata = d;
    endtask

    task automatic wait_resp(input string name, output int cycles);
        exp_t e;
        bit got;
        got = 1'b0;
        cycles = 0;
        #1;
        while (!got && cycles < 100) begin
            if (mem_resp) got = 1'b1;
            else begin
                @(negedge clk); #1;
                cycles++;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_resp timeout: mem_resp=0 required 1", name);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb: mem_resp with no outstanding request", name);
        end else begin
            e = sb.pop_front();
            if (!e.w) begin
                checks++;
                if (mem_rdata !== e.d) begin
                    failures++;
                    $display("FAIL %s_rdata: got %h required %h", name, mem_rdata, e.d);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic access(input string name, input logic w, input logic [15:0] a,
                          input logic [1:0] b, input logic [15:0] d, input int exp_cycles);
        int cyc;
        @(negedge clk);
        issue(w, a, b, d);
        wait_resp(name, cyc);
        chk({name, "_latency"}, 128'(cyc), 128'(exp_cycles));
    endtask

    task automatic idle();
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h1234;
        mem_byte_enable = 2'b11; mem_wdata = 16'hFFFF;
        #1 reset_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_mem_resp", 128'(mem_resp), 0);
        chk("rst_mem_rdata", 128'(mem_rdata), 0);
        chk("rst_pmem_strobes", 128'({pmem_read, pmem_write}), 0);
        chk("rst_pmem_address", 128'(pmem_address), 0);
        chk("rst_dp_loads", 128'({dp_load_word, dp_load_line}), 0);
        chk("rst_dp_in_word", 128'(dp_in_word), 0);
        chk("rst_dp_index_offset", 128'({dp_index, dp_offset}), 128'({3'd3, 3'd2}));
        mem_read = 1'b0;
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_cold_read();
        pmem_log.delete();
        access("cold_read", 1'b0, 16'h1234, 2'b11, 16'h0, LAT + 1);
        chk("cold_read_rdata_word2", 128'(mem_rdata), 128'(16'h5566));
        chk("cold_read_pmem_count", 128'(pmem_log.size()), 1);
        if (pmem_log.size() >= 1) chk("cold_read_pmem_txn", 128'({pmem_log[0].w, pmem_log[0].a}), 128'({1'b0, 16'h1230}));
    endtask

    task automatic test_write_hit();
        access("write_hit", 1'b1, 16'h1234, 2'b01, 16'hABCD, 0);
        chk("write_hit_load_word", 128'(dp_load_word), 1);
        access("write_readback", 1'b0, 16'h1234, 2'b11, 16'h0, 0);
        chk("write_readback_value", 128'(mem_rdata), 128'(16'h55CD));
    endtask

    task automatic test_dirty_conflict();
        pmem_log.delete();
        access("dirty_conflict", 1'b0, 16'h5234, 2'b11, 16'h0, 2 * LAT + 1);
        chk("dirty_conflict_pmem_count", 128'(pmem_log.size()), 2);
        if (pmem_log.size() == 2) begin
            chk("dirty_wb_txn", 128'({pmem_log[0].w, pmem_log[0].a}), 128'({1'b1, 16'h1230}));
            chk("dirty_wb_word2", 128'(pmem_log[0].d[47:32]), 128'(16'h55CD));
            chk("dirty_alloc_txn", 128'({pmem_log[1].w, pmem_log[1].a}), 128'({1'b0, 16'h5230}));
        end
    endtask

    task automatic test_back_to_back();
        int busy0;
        int cyc;
        access("refetch_1230", 1'b0, 16'h1234, 2'b11, 16'h0, LAT + 1);
        busy0 = pmem_busy;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            issue(1'b0, 16'h1230 + 16'(2 * i), 2'b11, 16'h0);
            wait_resp("b2b", cyc);
            chk("b2b_zero_wait", 128'(cyc), 0);
        end
        chk("b2b_no_pmem", 128'(pmem_busy - busy0), 0);
    endtask

    task automatic test_late_resp();
        idle();
        late_req++;
        @(negedge clk); #1;
        chk("late_resp_dp_loads", 128'({dp_load_word, dp_load_line}), 0);
        chk("late_resp_outputs", 128'({mem_resp, pmem_read, pmem_write}), 0);
        @(negedge clk);
        access("late_resp_still_hit", 1'b0, 16'h123E, 2'b11, 16'h0, 0);
    endtask

    task automatic test_drop_request();
        int resp_seen;
        idle();
        pmem_log.delete();
        mem_read = 1'b1; mem_address = 16'h0010;
        @(negedge clk);
        mem_read = 1'b0;
        resp_seen = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk); #1;
            if (mem_resp) resp_seen++;
        end
        chk("drop_no_resp", 128'(resp_seen), 0);
        chk("drop_fill_done", 128'({pmem_read, pmem_log.size()}), 128'({1'b0, 32'd1}));
        access("drop_then_hit", 1'b0, 16'h0010, 2'b11, 16'h0, 0);
    endtask

    task automatic test_reset_mid_alloc();
        idle();
        pmem_auto = 1'b0;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 16'h0020;
        @(negedge clk); #1;
        chk("mid_alloc_pmem_read", 128'(pmem_read), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_alloc_reset_drop", 128'({pmem_read, pmem_write, dp_load_line}), 0);
        mem_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pmem_auto = 1'b1;
        access("after_reset_same_addr", 1'b0, 16'h0020, 2'b11, 16'h0, LAT + 1);
        access("after_reset_other_set", 1'b0, 16'h0010, 2'b11, 16'h0, LAT + 1);
    endtask

    task automatic test_byte_lanes();
        access("write_miss_hi", 1'b1, 16'h2004, 2'b10, 16'h9900, LAT + 1);
        access("write_hit_both", 1'b1, 16'h2006, 2'b11, 16'hBEEF, 0);
        access("write_hit_none", 1'b1, 16'h2004, 2'b00, 16'hFFFF, 0);
        access("read_hi_lane", 1'b0, 16'h2004, 2'b11, 16'h0, 0);
        access("read_both_lanes", 1'b0, 16'h2006, 2'b11, 16'h0, 0);
        pmem_log.delete();
        access("evict_2000", 1'b0, 16'h6004, 2'b11, 16'h0, 2 * LAT + 1);
        if (pmem_log.size() >= 1) chk("evict_2000_wb", 128'({pmem_log[0].w, pmem_log[0].a}), 128'({1'b1, 16'h2000}));
        access("reload_2000", 1'b0, 16'h2004, 2'b11, 16'h0, LAT + 1);
        access("reload_2006", 1'b0, 16'h2006, 2'b11, 16'h0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_conflict();
        test_back_to_back();
        test_late_resp();
        test_drop_request();
        test_reset_mid_alloc();
        test_byte_lanes();
        idle();
        chk("scoreboard_drained", 128'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
